// File: rtl/rst_seq_ctrl.sv
// Multi-channel reset sequencer: asynchronous assert, synchronised staggered release,
// masked software warm reset. Optional RST_CAUSE output enabled by macro RST_CAUSE_EN.
module rst_seq_ctrl #(
  parameter int NUM_STAGES = 2,
  parameter int NUM_CH     = 3,
  parameter int HOLDOFF    = 4,
  parameter int STAGGER    = 3,
  parameter int SW_HOLD    = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SW_RST_REQ,
  input  logic [NUM_CH-1:0] CH_MASK,
  output logic [NUM_CH-1:0] SYNC_RST,
  output logic              RST_DONE,
  output logic              BUSY
`ifdef RST_CAUSE_EN
  ,
  output logic [1:0]        RST_CAUSE
`endif
);

  localparam int MAX_A   = (HOLDOFF > STAGGER) ? HOLDOFF : STAGGER;
  localparam int MAX_CNT = (MAX_A > SW_HOLD) ? MAX_A : SW_HOLD;
  localparam int CNT_W   = (MAX_CNT > 0) ? $clog2(MAX_CNT + 1) : 1;
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] HOLDOFF_M1 = CNT_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] STAGGER_M1 = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0] SW_HOLD_M1 = CNT_W'(SW_HOLD - 1);

  typedef enum logic [2:0] {
    HOLD,
    HOLDOFF_WAIT,
    RELEASE,
    RUN,
    SW_ASSERT,
    SW_RELEASE
  } state_t;

  state_t                state;
  logic [NUM_STAGES-1:0] sync_chain;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      ch_idx;
  logic [NUM_CH-1:0]     mask_q;

  logic                  rst_s;
  logic                  rst_rise;
  logic                  fire;
  logic                  has_next;
  logic [IDX_W-1:0]      next_idx;
  logic [IDX_W-1:0]      first_idx;
  logic [NUM_CH-1:0]     scan_mask;

  assign rst_s    = sync_chain[NUM_STAGES-1];
  // The release decision is taken on the edge where rst_s itself goes high, so a
  // zero holdoff puts channel 0 out on exactly edge NUM_STAGES.
  assign rst_rise = sync_chain[NUM_STAGES-2] & ~rst_s;

  // NOTE: every variable gets a default before the case/loop so no latch is inferred.
  always_comb begin
    fire      = 1'b0;
    has_next  = 1'b0;
    next_idx  = '0;
    first_idx = '0;
    scan_mask = (state == SW_ASSERT || state == SW_RELEASE) ? mask_q : '1;
    case (state)
      HOLD:                                       fire = rst_rise && (HOLDOFF == 0);
      HOLDOFF_WAIT, RELEASE, SW_ASSERT, SW_RELEASE: fire = (cnt == '0);
      default:                                    fire = 1'b0;
    endcase
    // Descending scan leaves the lowest qualifying index in each result.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (scan_mask[i] && (IDX_W'(i) > ch_idx)) begin
        next_idx = IDX_W'(i);
        has_next = 1'b1;
      end
      if (CH_MASK[i]) first_idx = IDX_W'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= HOLD;
      sync_chain <= '0;
      cnt        <= '0;
      ch_idx     <= '0;
      mask_q     <= '0;
      SYNC_RST   <= '0;
      RST_DONE   <= 1'b0;
      BUSY       <= 1'b1;
`ifdef RST_CAUSE_EN
      RST_CAUSE  <= 2'b01;
`endif
    end else begin
      sync_chain <= {sync_chain[NUM_STAGES-2:0], 1'b1};
      if (fire) begin
        SYNC_RST[ch_idx] <= 1'b1;
        if (has_next) begin
          ch_idx <= next_idx;
          cnt    <= STAGGER_M1;
          state  <= (state == SW_ASSERT || state == SW_RELEASE) ? SW_RELEASE : RELEASE;
        end else begin
          state    <= RUN;
          RST_DONE <= 1'b1;
          BUSY     <= 1'b0;
        end
      end else begin
        case (state)
          HOLD: begin
            if (rst_rise) begin
              state <= HOLDOFF_WAIT;
              cnt   <= HOLDOFF_M1;
            end
          end
          HOLDOFF_WAIT, RELEASE, SW_ASSERT, SW_RELEASE: cnt <= cnt - 1'b1;
          RUN: begin
            if (SW_RST_REQ && (|CH_MASK)) begin
              mask_q   <= CH_MASK;
              ch_idx   <= first_idx;
              cnt      <= SW_HOLD_M1;
              SYNC_RST <= SYNC_RST & ~CH_MASK;
              RST_DONE <= 1'b0;
              BUSY     <= 1'b1;
              state    <= SW_ASSERT;
`ifdef RST_CAUSE_EN
              RST_CAUSE <= 2'b10;
            end else if (SW_RST_REQ) begin
              RST_CAUSE <= 2'b00;
`endif
            end
          end
          default: state <= HOLD;
        endcase
      end
    end
  end

endmodule
